// File: rtl/pipe_mem_wb_skid.sv
// ---------------------------------------------------------------------------
// pipe_mem_wb_skid
//
// MEM -> WB pipeline register with a one-entry skid buffer. Entries flow in
// acceptance order through a head register (which drives the *_w outputs)
// and a skid register that catches one extra entry while WB stalls.
// in_ready is registered, so the upstream handshake never has a
// combinational path from out_ready.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   flush        synchronous flush; discards both entries (beats accept)
//   in_valid     MEM entry valid
//   in_ready     block can accept an entry this cycle (registered)
//   rd_data      memory read data            [DATA_W]
//   alu_out      ALU result                  [DATA_W]
//   wa3          destination register        [ADDR_W]
//   ctl_in       {mem_to_reg, reg_write, pc_src}
//   out_valid    head entry valid
//   out_ready    WB consumes the head entry this cycle
//   read_data_w  head read data (0 when empty)
//   alu_out_w    head ALU result (0 when empty)
//   wa3_w        head destination register (0 when empty)
//   ctl_w        head control bits (0 when empty)
//   result_w     mem_to_reg ? read_data_w : alu_out_w
//   wb_en        out_valid & out_ready & reg_write
//   occupancy    number of held entries, 0..2
// ---------------------------------------------------------------------------
module pipe_mem_wb_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [2:0]        ctl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] read_data_w,
  output logic [DATA_W-1:0] alu_out_w,
  output logic [ADDR_W-1:0] wa3_w,
  output logic [2:0]        ctl_w,
  output logic [DATA_W-1:0] result_w,
  output logic              wb_en,
  output logic [1:0]        occupancy
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] alu;
    logic [ADDR_W-1:0] wa;
    logic [2:0]        ctl;
  } entry_t;

  localparam entry_t ENTRY_ZERO = '0;

  state_t state_q, state_d;
  entry_t head_q,  head_d;
  entry_t skid_q,  skid_d;
  logic   in_ready_q, in_ready_d;

  entry_t in_entry;
  logic   accept;
  logic   pop;

  assign in_entry = '{rd: rd_data, alu: alu_out, wa: wa3, ctl: ctl_in};

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  // Next-state: the head is zeroed whenever it becomes empty so the *_w
  // outputs read 0 without extra output masking.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = EMPTY;
      head_d  = ENTRY_ZERO;
      skid_d  = ENTRY_ZERO;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_d  = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = FULL;
          end else if (pop) begin
            head_d  = ENTRY_ZERO;
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is 0 here, so only a pop can happen.
          if (pop) begin
            head_d  = skid_q;
            skid_d  = ENTRY_ZERO;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = ENTRY_ZERO;
          skid_d  = ENTRY_ZERO;
        end
      endcase
    end

    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= EMPTY;
      head_q     <= ENTRY_ZERO;
      skid_q     <= ENTRY_ZERO;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign read_data_w = head_q.rd;
  assign alu_out_w   = head_q.alu;
  assign wa3_w       = head_q.wa;
  assign ctl_w       = head_q.ctl;
  assign occupancy   = state_q;

  assign result_w = ctl_w[2] ? read_data_w : alu_out_w;
  assign wb_en    = out_valid & out_ready & ctl_w[1];

endmodule

// File: tb/tb_pipe_mem_wb_skid.sv
module tb_pipe_mem_wb_skid;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] alu_out;
  logic [ADDR_W-1:0] wa3;
  logic [2:0]        ctl_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] read_data_w;
  logic [DATA_W-1:0] alu_out_w;
  logic [ADDR_W-1:0] wa3_w;
  logic [2:0]        ctl_w;
  logic [DATA_W-1:0] result_w;
  logic              wb_en;
  logic [1:0]        occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_mem_wb_skid #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rd_data    (rd_data),
    .alu_out    (alu_out),
    .wa3        (wa3),
    .ctl_in     (ctl_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .read_data_w(read_data_w),
    .alu_out_w  (alu_out_w),
    .wa3_w      (wa3_w),
    .ctl_w      (ctl_w),
    .result_w   (result_w),
    .wb_en      (wb_en),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rd_data = '0; alu_out = '0; wa3 = '0; ctl_in = '0;

    // Reset state
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result_w, 0);
    reset = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // Stream with out_ready=1
    out_ready = 1'b1; in_valid = 1'b1; ctl_in = 3'b010; wa3 = 4'd1; alu_out = 32'h11;
    step();
    chk("stream1_result", result_w, 32'h11);
    chk("stream1_wb_en", wb_en, 1);
    chk("stream1_occ", occupancy, 1);
    alu_out = 32'h22;
    step();
    chk("stream2_result", result_w, 32'h22);
    chk("stream2_occ", occupancy, 1);
    alu_out = 32'h33;
    step();
    chk("stream3_result", result_w, 32'h33);
    chk("stream3_wb_en", wb_en, 1);
    in_valid = 1'b0;
    step();
    chk("stream_drain_occ", occupancy, 0);
    chk("stream_drain_valid", out_valid, 0);
    chk("stream_drain_result", result_w, 0);

    // Back-pressure
    out_ready = 1'b0; in_valid = 1'b1; alu_out = 32'hA;
    step();
    chk("bp_A_occ", occupancy, 1);
    chk("bp_A_result", result_w, 32'hA);
    chk("bp_A_in_ready", in_ready, 1);
    chk("bp_A_wb_en", wb_en, 0);
    alu_out = 32'hB;
    step();
    chk("bp_full_occ", occupancy, 2);
    chk("bp_full_in_ready", in_ready, 0);
    chk("bp_full_head", result_w, 32'hA);
    alu_out = 32'hC;   // offered while full: must not be taken
    step();
    chk("bp_stable_occ", occupancy, 2);
    chk("bp_stable_head", alu_out_w, 32'hA);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp_pop_wb_en", wb_en, 1);
    step();
    chk("bp_popA_head", result_w, 32'hB);
    chk("bp_popA_occ", occupancy, 1);
    chk("bp_popA_in_ready", in_ready, 1);
    step();
    chk("bp_popB_occ", occupancy, 0);
    chk("bp_popB_valid", out_valid, 0);

    // Result select: mem_to_reg=1, reg_write=0
    out_ready = 1'b0; in_valid = 1'b1;
    rd_data = 32'hDEAD_BEEF; alu_out = 32'h1234; ctl_in = 3'b100; wa3 = 4'd5;
    step();
    chk("sel_result", result_w, 32'hDEAD_BEEF);
    chk("sel_rd", read_data_w, 32'hDEAD_BEEF);
    chk("sel_alu", alu_out_w, 32'h1234);
    chk("sel_wa3", wa3_w, 5);
    chk("sel_ctl", ctl_w, 3'b100);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("sel_wb_en", wb_en, 0);
    step();
    chk("sel_pop_occ", occupancy, 0);

    // Flush while FULL with an offered entry
    out_ready = 1'b0; in_valid = 1'b1; rd_data = '0; ctl_in = 3'b010; wa3 = 4'd2;
    alu_out = 32'h51;
    step();
    alu_out = 32'h52;
    step();
    chk("fl_full_occ", occupancy, 2);
    alu_out = 32'h53; flush = 1'b1;
    step();
    chk("fl_occ", occupancy, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_rd", read_data_w, 0);
    chk("fl_alu", alu_out_w, 0);
    chk("fl_wa3", wa3_w, 0);
    chk("fl_ctl", ctl_w, 0);
    chk("fl_result", result_w, 0);
    chk("fl_in_ready", in_ready, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("fl_no_stale_occ", occupancy, 0);
    chk("fl_no_stale_valid", out_valid, 0);

    // Flush beats a simultaneous accept in ONE
    out_ready = 1'b0; in_valid = 1'b1; alu_out = 32'h61;
    step();
    chk("fl1_occ", occupancy, 1);
    flush = 1'b1; alu_out = 32'h62;
    step();
    chk("fl1_after_occ", occupancy, 0);
    chk("fl1_after_result", result_w, 0);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("fl1_dropped_occ", occupancy, 0);

    // Reset while FULL
    in_valid = 1'b1; alu_out = 32'h71;
    step();
    alu_out = 32'h72;
    step();
    chk("rs_full_occ", occupancy, 2);
    reset = 1'b0; in_valid = 1'b0;
    step();
    chk("rs_occ", occupancy, 0);
    chk("rs_in_ready", in_ready, 0);
    chk("rs_valid", out_valid, 0);
    chk("rs_result", result_w, 0);
    chk("rs_ctl", ctl_w, 0);
    chk("rs_wa3", wa3_w, 0);
    reset = 1'b1;
    step();
    chk("rs_rel_in_ready", in_ready, 1);
    chk("rs_rel_occ", occupancy, 0);
    out_ready = 1'b1;
    step();
    chk("rs_no_stale_valid", out_valid, 0);
    in_valid = 1'b1; alu_out = 32'h81;
    step();
    chk("rs_new_result", result_w, 32'h81);
    chk("rs_new_occ", occupancy, 1);
    in_valid = 1'b0;
    step();
    chk("rs_new_drain", occupancy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_mem_wb_skid.md
PIPE_MEM_WB_SKID -- requirements
Module: pipe_mem_wb_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of the memory-data and ALU-result fields.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning the width of the write-back register address.
REQ-003 The block SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-005 The block SHALL have port flush  in  1  synchronous pipeline flush.
REQ-006 The block SHALL have port in_valid  in  1  upstream (MEM) entry is valid.
REQ-007 The block SHALL have port in_ready  out  1  the block can accept an entry this cycle.
REQ-008 The block SHALL have port rd_data  in  DATA_W  memory read data from MEM.
REQ-009 The block SHALL have port alu_out  in  DATA_W  ALU result from MEM.
REQ-010 The block SHALL have port wa3  in  ADDR_W  destination register address from MEM.
REQ-011 The block SHALL have port ctl_in  in  3  {mem_to_reg, reg_write, pc_src} from MEM.
REQ-012 The block SHALL have port out_valid  out  1  the WB entry is valid.
REQ-013 The block SHALL have port out_ready  in  1  WB consumes the entry this cycle.
REQ-014 The block SHALL have port read_data_w, alu_out_w  out  DATA_W each  registered copies of the head entry.
REQ-015 The block SHALL have port wa3_w  out  ADDR_W  registered destination address of the head entry.
REQ-016 The block SHALL have port ctl_w  out  3  registered {mem_to_reg, reg_write, pc_src} of the head entry.
REQ-017 The block SHALL have port result_w  out  DATA_W  selected write-back value.
REQ-018 The block SHALL have port wb_en  out  1  register-file write strobe.
REQ-019 The block SHALL have port occupancy  out  2  number of held entries (0..2).

Function
REQ-020 Storage SHALL be two entries: a head register (drives the _w outputs) and a skid register; every entry holds all data and control fields.
REQ-021 The state SHALL be one of EMPTY (occupancy 0), ONE (head valid), or FULL (head and skid valid); out_valid SHALL be 1 in ONE and FULL.
REQ-022 in_ready SHALL be a registered signal equal to 1 exactly when the state is not FULL; it SHALL NOT depend combinationally on out_ready.
REQ-023 An accept SHALL occur when in_valid=1 and in_ready=1; a pop SHALL occur when out_valid=1 and out_ready=1.
REQ-024 EMPTY + accept SHALL load head and go to ONE; the entry appears on the outputs one cycle after accept (latency 1).
REQ-025 ONE + accept without pop SHALL load skid and go to FULL; ONE + pop without accept SHALL go to EMPTY; ONE + accept + pop SHALL load head with the new entry and stay ONE.
REQ-026 FULL + pop SHALL move skid to head and go to ONE; no accept is possible in FULL.
REQ-027 Entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated except by flush or reset.
REQ-028 flush=1 SHALL discard both entries and go to EMPTY at the next edge; flush SHALL take priority over a simultaneous accept (the offered entry is dropped); in_ready SHALL be 1 in the following cycle.
REQ-029 When out_valid=0, read_data_w, alu_out_w, wa3_w, ctl_w and result_w SHALL all be 0.
REQ-030 result_w SHALL be combinational: read_data_w when ctl_w[2] (mem_to_reg)=1, else alu_out_w.
REQ-031 wb_en SHALL equal out_valid AND out_ready AND ctl_w[1] (reg_write).
REQ-032 The head outputs SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-033 While reset=0 at a rising edge, the block SHALL go to EMPTY with all stored fields, all outputs, and in_ready cleared to 0; reset SHALL override flush, accept and pop.
REQ-034 in_ready SHALL be 1 in the first cycle after reset returns to 1; reset asserted mid-transfer SHALL discard all held entries.

Verification
REQ-035 Stream: out_ready=1, accept alu_out=0x11,0x22,0x33 on consecutive cycles with mem_to_reg=0, reg_write=1 -> result_w 0x11,0x22,0x33 one cycle later each, wb_en=1, occupancy stays 1.
REQ-036 Back-pressure: out_ready=0, accept A=0xA, B=0xB -> occupancy 2, in_ready=0, head=A stable; out_ready=1 -> A then B in order, in_ready returns to 1.
REQ-037 Select: rd_data=0xDEAD_BEEF, alu_out=0x1234, mem_to_reg=1, reg_write=0 -> result_w=0xDEAD_BEEF, wb_en=0 when popped.
REQ-038 Flush in FULL with in_valid=1 -> next cycle occupancy 0, out_valid=0, all _w outputs 0, in_ready=1, offered entry never appears.
REQ-039 Reset=0 for one cycle while FULL -> all outputs 0, in_ready=0 during reset, in_ready=1 the following cycle, no stale entry appears afterwards.
